// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and helpers for the forwarding/hazard controller
package fwd_pkg;

    // Tag rd field is sized for the widest supported register file; narrower
    // addresses are zero-extended before being stored or compared.
    localparam int FWD_RD_W   = 8;
    localparam int FWD_SEL_RF = 0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } fwd_state_t;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                we;
        logic                is_load;
    } fwd_tag_t;

    localparam fwd_tag_t FWD_TAG_NONE = '0;

    // A slot produces a value for r only if it really writes r; x0 never matches.
    function automatic logic tag_match(input fwd_tag_t t, input logic [FWD_RD_W-1:0] r);
        return t.valid & t.we & (t.rd == r) & (|r);
    endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// rtl/fwd_tag_pipe.sv - destination-tag shift register, slot0 = instruction in EX
module fwd_tag_pipe
    import fwd_pkg::*;
#(
    parameter int DEPTH = 3
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic                   kill,
    input  logic                   load,
    input  fwd_tag_t               in_tag,
    output fwd_tag_t [DEPTH-1:0]   slot
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (!hold) begin
            // A stalled or killed ID turns into a bubble entering EX.
            slot[0] <= (load && !kill) ? in_tag : FWD_TAG_NONE;
            for (int k = 1; k < DEPTH; k++) begin
                slot[k] <= slot[k-1];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - bypass selects, load-use stall/bubble and memory-wait freeze
// Optional saturating perf counters are built when FWD_STATS_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int NUM_SRC        = 2,
    parameter  int NUM_FWD_STAGES = 2,
    parameter  int LOAD_FWD_SLOT  = 2,
    parameter  int REG_AW         = 5,
    parameter  int CNT_W          = 32,
    localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic                      dmem_stall,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic                      freeze,
    output logic [CNT_W-1:0]          stat_stall_cnt,
    output logic [CNT_W-1:0]          stat_fwd_cnt
);

    fwd_tag_t [NUM_FWD_STAGES:0] slot;
    fwd_tag_t                    id_tag;
    fwd_state_t                  state;
    fwd_state_t                  state_nxt;
    logic                        flush_pend;
    logic                        kill;
    logic                        load_hit;
    logic                        unused_tag_bits;

    function automatic logic [FWD_RD_W-1:0] widen(input logic [REG_AW-1:0] r);
        logic [FWD_RD_W-1:0] w;
        w            = '0;
        w[REG_AW-1:0] = r;
        return w;
    endfunction

    always_comb begin
        id_tag              = FWD_TAG_NONE;
        id_tag.valid        = id_valid;
        id_tag.rd[REG_AW-1:0] = id_rd;
        id_tag.we           = id_we;
        id_tag.is_load      = id_is_load;
    end

    // A flush seen while frozen is remembered and applied at the first moving edge.
    assign kill = flush | flush_pend;

    fwd_tag_pipe #(
        .DEPTH (NUM_FWD_STAGES + 1)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (freeze),
        .kill   (kill),
        .load   (~stall),
        .in_tag (id_tag),
        .slot   (slot)
    );

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
                if (tag_match(slot[k], widen(ex_rs[i*REG_AW +: REG_AW]))) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j <= LOAD_FWD_SLOT - 2; j++) begin
                if (slot[j].is_load && tag_match(slot[j], widen(id_rs[i*REG_AW +: REG_AW]))) begin
                    load_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        unused_tag_bits = 1'b0;
        for (int k = 0; k <= NUM_FWD_STAGES; k++) begin
            unused_tag_bits = unused_tag_bits ^ slot[k].is_load;
        end
    end

    assign stall  = id_valid & load_hit & ~freeze;
    assign bubble = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      state_nxt = dmem_stall ? MEM_WAIT : RUN;
            MEM_WAIT: state_nxt = dmem_stall ? MEM_WAIT : RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Leaving MEM_WAIT releases the pipeline in the same cycle memory answers.
    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:      freeze = dmem_stall;
            MEM_WAIT: freeze = dmem_stall;
            default:  freeze = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else if (freeze) begin
            if (flush) begin
                flush_pend <= 1'b1;
            end
        end else begin
            flush_pend <= 1'b0;
        end
    end

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;
    logic             fwd_any;

    assign fwd_any = |fwd_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!freeze && fwd_any && !(&fwd_cnt)) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign stat_stall_cnt = stall_cnt;
    assign stat_fwd_cnt   = fwd_cnt;
`else
    assign stat_stall_cnt = '0;
    assign stat_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit against an in-flight instruction model
module tb_fwd_hazard_unit;

    localparam int NS  = 2;
    localparam int NF  = 2;
    localparam int LFS = 2;
    localparam int RA  = 5;
    localparam int CW  = 32;
    localparam int SW  = $clog2(NF + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [NS*RA-1:0]  id_rs;
    logic [RA-1:0]     id_rd;
    logic              id_we;
    logic              id_is_load;
    logic [NS*RA-1:0]  ex_rs;
    logic              dmem_stall;
    logic              flush;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic              bubble;
    logic              freeze;
    logic [CW-1:0]     stat_stall_cnt;
    logic [CW-1:0]     stat_fwd_cnt;

    fwd_hazard_unit #(
        .NUM_SRC        (NS),
        .NUM_FWD_STAGES (NF),
        .LOAD_FWD_SLOT  (LFS),
        .REG_AW         (RA),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rd          (id_rd),
        .id_we          (id_we),
        .id_is_load     (id_is_load),
        .ex_rs          (ex_rs),
        .dmem_stall     (dmem_stall),
        .flush          (flush),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .bubble         (bubble),
        .freeze         (freeze),
        .stat_stall_cnt (stat_stall_cnt),
        .stat_fwd_cnt   (stat_fwd_cnt)
    );

    always #5 clk = ~clk;

    // Model: queue of in-flight instructions, index 0 is the one in EX.
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } mtag_t;

    typedef struct packed {
        logic [NS*SW-1:0] sel;
        logic             stall;
        logic             freeze;
        logic [CW-1:0]    scnt;
        logic [CW-1:0]    fcnt;
    } exp_t;

    mtag_t       pipe[$];
    exp_t        exp_q[$];
    bit          c_idv, c_we, c_ld, c_dm, c_fl;
    int          c_rs[NS];
    int          c_ex[NS];
    int          c_rd;
    bit          pend;
    bit          e_stall, e_freeze, e_any;
    int unsigned m_scnt, m_fcnt;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic bit hit(input mtag_t t, input int r);
        return t.v && t.we && (t.rd == r) && (r != 0);
    endfunction

    task automatic drive();
        id_valid   = c_idv;
        id_rs      = {RA'(c_rs[1]), RA'(c_rs[0])};
        id_rd      = RA'(c_rd);
        id_we      = c_we;
        id_is_load = c_ld;
        ex_rs      = {RA'(c_ex[1]), RA'(c_ex[0])};
        dmem_stall = c_dm;
        flush      = c_fl;
    endtask

    task automatic compute(output exp_t e);
        int s;
        e        = '0;
        e_freeze = c_dm;
        e_any    = 1'b0;
        for (int i = 0; i < NS; i++) begin
            s = 0;
            for (int k = 1; k <= NF; k++)
                if (s == 0 && hit(pipe[k], c_ex[i])) s = k;
            e.sel[i*SW +: SW] = SW'(s);
            if (s != 0) e_any = 1'b1;
        end
        e_stall = 1'b0;
        if (!e_freeze && c_idv)
            for (int i = 0; i < NS; i++)
                for (int j = 0; j <= LFS - 2; j++)
                    if (pipe[j].ld && hit(pipe[j], c_rs[i])) e_stall = 1'b1;
        e.stall  = e_stall;
        e.freeze = e_freeze;
`ifdef FWD_STATS_EN
        e.scnt = CW'(m_scnt);
        e.fcnt = CW'(m_fcnt);
`endif
    endtask

    task automatic advance();
        mtag_t nt;
        if (e_stall) m_scnt++;
        if (!e_freeze && e_any) m_fcnt++;
        if (!c_dm) begin
            nt = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
            if (c_idv && !(c_fl || pend) && !e_stall)
                nt = '{v: 1'b1, rd: c_rd, we: c_we, ld: c_ld};
            pipe.push_front(nt);
            void'(pipe.pop_back());
            pend = 1'b0;
        end else if (c_fl) begin
            pend = 1'b1;
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int k = 0; k <= NF; k++) pipe.push_back('{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0});
        pend = 0; m_scnt = 0; m_fcnt = 0;
        c_idv = 0; c_we = 0; c_ld = 0; c_dm = 0; c_fl = 0; c_rd = 0;
        c_rs[0] = 0; c_rs[1] = 0; c_ex[0] = 0; c_ex[1] = 0;
        e_stall = 0; e_freeze = 0; e_any = 0;
        drive();
    endtask

    task automatic cyc(input bit idv, input int rs0, input int rs1, input int rd,
                       input bit we, input bit ld, input int ex0, input int ex1,
                       input bit dm, input bit fl);
        exp_t e;
        @(posedge clk);
        advance();
        #1;
        c_idv = idv; c_rs[0] = rs0; c_rs[1] = rs1; c_rd = rd; c_we = we; c_ld = ld;
        c_ex[0] = ex0; c_ex[1] = ex1; c_dm = dm; c_fl = fl;
        drive();
        compute(e);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fwd_sel", fwd_sel, e.sel);
                chk("stall", stall, e.stall);
                chk("bubble", bubble, e.stall);
                chk("freeze", freeze, e.freeze);
                chk("stat_stall_cnt", stat_stall_cnt, e.scnt);
                chk("stat_fwd_cnt", stat_fwd_cnt, e.fcnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_fwd_sel", fwd_sel, 0);
        chk("reset_stall", stall, 0);
        chk("reset_bubble", bubble, 0);
        chk("reset_freeze", freeze, 0);
        chk("reset_stall_cnt", stat_stall_cnt, 0);
        chk("reset_fwd_cnt", stat_fwd_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back ALU: add x5, consumer in EX sees slot1
        cyc(1, 1, 2, 5, 1, 0, 0, 0, 0, 0);
        cyc(1, 5, 0, 9, 1, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        #2;
        chk("alu_fwd", fwd_sel[SW-1:0], 1);
        chk("alu_nostall", stall, 0);

        // load-use: one bubble then bypass from slot2
        cyc(1, 1, 0, 6, 1, 1, 0, 0, 0, 0);
        cyc(1, 6, 1, 7, 1, 0, 0, 0, 0, 0);
        #2;
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        cyc(1, 6, 1, 7, 1, 0, 0, 0, 0, 0);
        #2;
        chk("lu_stall_once", stall, 0);
        cyc(0, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        #2;
        chk("lu_fwd", fwd_sel[SW-1:0], 2);

        // async reset during a stall
        cyc(1, 1, 0, 6, 1, 1, 0, 0, 0, 0);
        cyc(1, 6, 1, 7, 1, 0, 0, 0, 0, 0);
        #2;
        chk("rst_pre_stall", stall, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_stall", stall, 0);
        chk("rst_async_bubble", bubble, 0);
        chk("rst_async_sel", fwd_sel, 0);
        chk("rst_async_freeze", freeze, 0);
        chk("rst_async_scnt", stat_stall_cnt, 0);
        chk("rst_async_fcnt", stat_fwd_cnt, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 6, 7, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 6, 7, 0, 0);
        #2;
        chk("rst_no_stale", fwd_sel, 0);

        // five load-use stalls
        repeat (5) begin
            cyc(1, 1, 0, 6, 1, 1, 0, 0, 0, 0);
            cyc(1, 6, 0, 7, 1, 0, 0, 0, 0, 0);
            cyc(1, 6, 0, 7, 1, 0, 0, 0, 0, 0);
        end
        idle();
        #2;
`ifdef FWD_STATS_EN
        chk("stat_five_stalls", stat_stall_cnt, 5);
`else
        chk("stat_tied_zero", stat_stall_cnt, 0);
`endif

        // x8 written twice: youngest wins; x0 never forwards
        cyc(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 8, 0, 0, 0);
        #2;
        chk("young_wins", fwd_sel[SW-1:0], 1);
        chk("x0_sel1", fwd_sel[2*SW-1:SW], 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("x0_never", fwd_sel, 0);

        // three-cycle memory wait with a pending load-use
        cyc(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 12, 1, 1, 0, 0, 0, 0);
        repeat (3) begin
            cyc(1, 12, 0, 13, 1, 0, 10, 0, 1, 0);
            #2;
            chk("wait_freeze", freeze, 1);
            chk("wait_nostall", stall, 0);
            chk("wait_tags_held", fwd_sel[SW-1:0], 1);
        end
        cyc(1, 12, 0, 13, 1, 0, 10, 0, 0, 0);
        #2;
        chk("wait_release", freeze, 0);
        chk("wait_resume_stall", stall, 1);

        // flush while frozen drops the ID tag at the first moving edge
        repeat (3) idle();
        cyc(1, 0, 0, 13, 1, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 13, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 13, 1, 0, 0, 0, 0, 0);
        repeat (3) begin
            cyc(0, 0, 0, 0, 0, 0, 13, 0, 0, 0);
            #2;
            chk("flush_no_fwd", fwd_sel[SW-1:0], 0);
        end

        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(99) < 80),
                int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)),
                ($urandom_range(99) < 75), ($urandom_range(99) < 30),
                int'($urandom_range(7)), int'($urandom_range(7)),
                ($urandom_range(99) < 15), ($urandom_range(99) < 10));
        end

        repeat (2) idle();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
